// File: rtl/multiplier_seq_carry_pkg.sv
// Shared definitions for the sequential shift-add multiplier and the ALU control.
// Latency: n/a (types and elaboration helpers only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - FSM encodings ST_IDLE=0, ST_BUSY=1, ST_DONE=2 (visible to ALU control)
//   cnt_width  - width of the bit counter for a given operand width
package multiplier_seq_carry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multiplier_seq_carry_dp.sv
// Shift-add datapath: operand registers, 2W-bit accumulator, bit counter, conditional add.
// Latency: one multiplier bit per step; acc_nxt/last are combinational from current state.
// Backpressure: none; load/step are issued by the owning FSM.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load           capture a, b; seed acc with carry_in; clear counter
//   step           process bit cnt of b_reg: acc += a_reg << cnt when set; cnt++
//   a, b, carry_in operands, sampled only on load
//   acc_nxt        accumulator value after the current step (result on the last step)
//   last           current step is the final one
// Build option MULT_EARLY_TERM_EN: last asserts once no higher bits of b_reg remain set.
module multiplier_seq_carry_dp
    import multiplier_seq_carry_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               carry_in,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    // b_reg shifted so the bit under consideration sits at position 0;
    // avoids a variable bit-select with a counter wider than the index range.
    logic [WIDTH-1:0]   b_cur;
    logic [2*WIDTH-1:0] addend;

    always_comb begin
        b_cur   = b_reg >> cnt;
        addend  = b_cur[0] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
        // (2^W-1)^2 + 1 fits in 2W bits, so this sum never wraps.
        acc_nxt = acc + addend;
`ifdef MULT_EARLY_TERM_EN
        // Equivalent to (b_reg >> (cnt+1)) == 0: nothing left to add after this bit.
        last    = (b_cur >> 1) == '0;
`else
        last    = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= {{(2*WIDTH-1){1'b0}}, carry_in};
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multiplier_seq_carry.sv
// Sequential shift-add multiplier, PRODUCT = A*B + carry_in, with carry_out = |PRODUCT high half.
// Latency: out_valid rises WIDTH clocks after the accept edge (fewer with early termination).
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (aborts any operation)
//   in_valid/in_ready    operand handshake; A, B, carry_in sampled on accept
//   out_valid/out_ready  result handshake; PRODUCT, carry_out meaningful while out_valid
//   busy                 high while computing or holding a result
// Build option MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero
// (latency max(1, msb index of B + 1)); results are identical either way.
module multiplier_seq_carry
    import multiplier_seq_carry_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic               carry_out,
    output logic               busy
);

    state_t             state;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] acc_nxt;

    // in_ready is a registered copy of (state == ST_IDLE).
    assign load = in_ready & in_valid;
    assign step = (state == ST_BUSY);

    multiplier_seq_carry_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .a        (A),
        .b        (B),
        .carry_in (carry_in),
        .acc_nxt  (acc_nxt),
        .last     (last)
    );

    // PRODUCT/carry_out are captured only on the final step, so they keep the
    // previous result through IDLE and BUSY instead of showing partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            PRODUCT   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        PRODUCT   <= acc_nxt;
                        carry_out <= |acc_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                ST_DONE: begin
                    // in_ready stays low here, so release and accept never share an edge.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq_carry.sv
// Bench for multiplier_seq_carry at WIDTH=4 and WIDTH=8 side by side.
// Drivers push expected results into per-instance queues; monitors pop on each handshake.
// Honours MULT_EARLY_TERM_EN when computing expected latency.
module tb_multiplier_seq_carry;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=8 instance
    logic        v8, ir8, ov8, or8, c8, co8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    // WIDTH=4 instance
    logic        v4, ir4, ov4, or4, c4, co4, bz4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    multiplier_seq_carry #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(ir8), .A(a8), .B(b8), .carry_in(c8),
        .out_valid(ov8), .out_ready(or8), .PRODUCT(p8), .carry_out(co8), .busy(bz8)
    );

    multiplier_seq_carry #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(ir4), .A(a4), .B(b4), .carry_in(c4),
        .out_valid(ov4), .out_ready(or4), .PRODUCT(p4), .carry_out(co4), .busy(bz4)
    );

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall8   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic logic [15:0] model_prod(input int a, input int b, input int c);
        return 16'(a * b + c);
    endfunction

    // Cycles from accept to out_valid: WIDTH, or the bit length of B (min 1) with early term.
    function automatic int model_lat(input int w, input int b);
        int msb = 1;
        for (int i = 0; i < w; i++)
            if (((b >> i) & 1) == 1) msb = i + 1;
`ifdef MULT_EARLY_TERM_EN
        return msb;
`else
        return (msb > 0) ? w : w;
`endif
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        v8 = 1'b1; a8 = a; b8 = b; c8 = c;
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d8_in_ready_for_accept", ir8, 1);
        if (!ir8) begin
            v8 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.prod    = model_prod(int'(a), int'(b), int'(c));
        e.lat     = model_lat(8, int'(b));
        e.acc_cyc = cyc;
        q8.push_back(e);
        // Operand changes after acceptance must not matter.
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        v4 = 1'b1; a4 = a; b4 = b; c4 = c;
        while (!ir4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d4_in_ready_for_accept", ir4, 1);
        if (!ir4) begin
            v4 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.prod    = model_prod(int'(a), int'(b), int'(c));
        e.lat     = model_lat(4, int'(b));
        e.acc_cyc = cyc;
        q4.push_back(e);
        v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_results", q8.size() + q4.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // out_ready drivers, updated shortly after each edge.
    initial begin
        or8 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ov8 && stall8 > 0) begin
                or8 = 1'b0;
                stall8--;
            end else begin
                or8 = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        or4 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            or4 = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor for WIDTH=8
    logic        seen8 = 1'b0;
    logic [15:0] held8 = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen8 = 1'b0;
            end else if (ov8) begin
                if (q8.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d8_spurious_valid: out_valid=1, required 0 (no op pending, cycle %0d)", cyc);
                end else begin
                    if (!seen8) begin
                        check("d8_latency", cyc - q8[0].acc_cyc, q8[0].lat);
                        seen8 = 1'b1;
                        held8 = p8;
                    end else begin
                        check("d8_product_held", p8, held8);
                    end
                    check("d8_in_ready_while_done", ir8, 0);
                    check("d8_busy_while_done", bz8, 1);
                    if (or8) begin
                        check("d8_product", p8, q8[0].prod);
                        check("d8_carry_out", co8, q8[0].prod[15:8] != 8'd0);
                        void'(q8.pop_front());
                        seen8 = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor for WIDTH=4
    logic       seen4 = 1'b0;
    logic [7:0] held4 = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen4 = 1'b0;
            end else if (ov4) begin
                if (q4.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d4_spurious_valid: out_valid=1, required 0 (no op pending, cycle %0d)", cyc);
                end else begin
                    if (!seen4) begin
                        check("d4_latency", cyc - q4[0].acc_cyc, q4[0].lat);
                        seen4 = 1'b1;
                        held4 = p4;
                    end else begin
                        check("d4_product_held", p4, held4);
                    end
                    check("d4_in_ready_while_done", ir4, 0);
                    check("d4_busy_while_done", bz4, 1);
                    if (or4) begin
                        check("d4_product", p4, q4[0].prod[7:0]);
                        check("d4_carry_out", co4, q4[0].prod[7:4] != 4'd0);
                        void'(q4.pop_front());
                        seen4 = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_d8_in_ready", ir8, 1);
        check("rst_d8_out_valid", ov8, 0);
        check("rst_d8_product", p8, 0);
        check("rst_d8_carry_out", co8, 0);
        check("rst_d8_busy", bz8, 0);
        check("rst_d4_in_ready", ir4, 1);
        check("rst_d4_out_valid", ov4, 0);
        check("rst_d4_product", p4, 0);
        rst = 1'b0;

        // Directed cases on both widths in parallel.
        fork
            begin
                issue4(4'd2, 4'd1, 1'b0);
                issue4(4'hB, 4'd3, 1'b0);
                issue4(4'd1, 4'd7, 1'b1);
                issue4(4'hF, 4'hF, 1'b1);
                issue4(4'd5, 4'd0, 1'b1);
                issue4(4'd9, 4'h8, 1'b0);
            end
            begin
                stall8 = 5;
                issue8(8'hFF, 8'hFF, 1'b1);
                issue8(8'h55, 8'h00, 1'b1);
                issue8(8'h01, 8'h80, 1'b0);
            end
        join
        drain();

        // Reset two clocks after accept aborts the operation.
        issue8(8'h12, 8'hF0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(q8.pop_back());
        @(posedge clk);
        #1;
        check("midop_rst_in_ready", ir8, 1);
        check("midop_rst_out_valid", ov8, 0);
        check("midop_rst_product", p8, 0);
        check("midop_rst_carry_out", co8, 0);
        check("midop_rst_busy", bz8, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midop_rst_no_valid", ov8, 0);
        issue8(8'd3, 8'd3, 1'b0);
        drain();

        // Random sweep on both widths.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    issue8(8'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    issue4(4'($urandom), (j % 10 == 0) ? 4'd0 : 4'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
